// File: rtl/onfi_pkg.sv
// Shared ONFI definitions: opcodes, feature addresses, SET FEATURES states and
// cycle-count helpers used by the ONFI command blocks.
package onfi_pkg;

  // Command opcodes
  localparam logic [7:0] CMD_SET_FEATURE = 8'hEF;
  localparam logic [7:0] CMD_GET_FEATURE = 8'hEE;

  // Feature addresses
  localparam logic [7:0] FA_TIMING_MODE  = 8'h01;
  localparam logic [7:0] FA_NVDDR2_CFG   = 8'h02;

  // Timing budgets in ns, converted to cycles with ns_to_cyc()
  localparam int unsigned T_ADL_NS  = 70;
  localparam int unsigned T_FEAT_NS = 2000;

  // SET FEATURES state encoding (plain constants for legacy tooling)
  typedef logic [3:0] sf_state_t;
  localparam sf_state_t SF_IDLE = 4'd0;
  localparam sf_state_t SF_CMD  = 4'd1;
  localparam sf_state_t SF_ADDR = 4'd2;
  localparam sf_state_t SF_ADL  = 4'd3;
  localparam sf_state_t SF_PRE  = 4'd4;
  localparam sf_state_t SF_DATA = 4'd5;
  localparam sf_state_t SF_POST = 4'd6;
  localparam sf_state_t SF_WAIT = 4'd7;
  localparam sf_state_t SF_DONE = 4'd8;

  // Round a delay in ns up to whole cycles of a clock given in MHz.
  function automatic int unsigned ns_to_cyc(input int unsigned ns, input int unsigned fre_mhz);
    return (ns * fre_mhz + 999) / 1000;
  endfunction

endpackage

// File: rtl/set_feature_if.sv
// Command handshake plus ONFI pin group for the SET FEATURES initiator.
// master = sequencer/device side, slave = the set_feature block.
interface set_feature_if #(
  parameter int unsigned DQ_W = 8
);
  logic            start;
  logic [7:0]      addr;
  logic [31:0]     param;
  logic            busy;
  logic            done;
  logic            timeout;
  logic            onfi_cen;
  logic            onfi_cle;
  logic            onfi_ale;
  logic            onfi_wen;
  logic [DQ_W-1:0] onfi_dq_o;
  logic            onfi_dq_en;
  logic            onfi_dqs_o;
  logic            onfi_dqs_en;
  logic            onfi_rb_n;

  modport master (
    output start, addr, param, onfi_rb_n,
    input  busy, done, timeout, onfi_cen, onfi_cle, onfi_ale, onfi_wen,
    input  onfi_dq_o, onfi_dq_en, onfi_dqs_o, onfi_dqs_en
  );

  modport slave (
    input  start, addr, param, onfi_rb_n,
    output busy, done, timeout, onfi_cen, onfi_cle, onfi_ale, onfi_wen,
    output onfi_dq_o, onfi_dq_en, onfi_dqs_o, onfi_dqs_en
  );
endinterface

// File: rtl/onfi_rb_sync.sv
// Two-flop synchroniser for the asynchronous R/B# pin.
module onfi_rb_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rb_n,
  output logic rb_n_sync
);
  logic meta_q, sync_q;

  // Resets to "busy" so no command can start before the pin has been sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= rb_n;
      sync_q <= meta_q;
    end
  end

  assign rb_n_sync = sync_q;
endmodule

// File: rtl/set_feature.sv
// ONFI SET FEATURES (EFh) initiator: command, feature address, tADL gap,
// four DDR parameter beats with DQS, then wait for R/B# (tFEAT) or time out.
module set_feature
  import onfi_pkg::*;
#(
  parameter int unsigned ONFI_FRE      = 200,
  parameter int unsigned DQ_W          = 8,
  parameter int unsigned T_ADL_CYC     = ns_to_cyc(T_ADL_NS, ONFI_FRE),  // must be >= 1
  parameter int unsigned T_FEAT_TO_CYC = ns_to_cyc(T_FEAT_NS, ONFI_FRE)
) (
  input logic          onfi_clk,
  input logic          onfi_rst_n,
  set_feature_if.slave bus
);
  localparam int unsigned CNT_MAX = (T_FEAT_TO_CYC > T_ADL_CYC) ? T_FEAT_TO_CYC : T_ADL_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t ADL_LOAD  = cnt_t'(T_ADL_CYC - 1);
  localparam cnt_t FEAT_LAST = cnt_t'(T_FEAT_TO_CYC - 1);
  localparam cnt_t FEAT_MAX  = cnt_t'(T_FEAT_TO_CYC);
  // WAIT cycles 1..2 after POST cover tWB plus synchroniser latency
  localparam cnt_t RB_IGNORE = cnt_t'(2);

  sf_state_t   state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [1:0]  beat_q, beat_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] param_q, param_d;
  logic        timeout_q, timeout_d;
  logic        rb_ready;
  logic [7:0]  dq_byte;

  onfi_rb_sync u_rb_sync (
    .clk       (onfi_clk),
    .rst_n     (onfi_rst_n),
    .rb_n      (bus.onfi_rb_n),
    .rb_n_sync (rb_ready)
  );

  // Next-state: sequencing, shared ADL/WAIT counter, request capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    param_d   = param_q;
    timeout_d = timeout_q;
    case (state_q)
      SF_IDLE: begin
        if (bus.start && rb_ready) begin
          addr_d    = bus.addr;
          param_d   = bus.param;
          timeout_d = 1'b0;
          state_d   = SF_CMD;
        end
      end
      SF_CMD:  state_d = SF_ADDR;
      SF_ADDR: begin
        state_d = SF_ADL;
        cnt_d   = ADL_LOAD;
      end
      SF_ADL: begin
        if (cnt_q == '0) state_d = SF_PRE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      SF_PRE: begin
        state_d = SF_DATA;
        beat_d  = 2'd0;
      end
      SF_DATA: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = SF_POST;
      end
      SF_POST: begin
        state_d = SF_WAIT;
        cnt_d   = cnt_t'(1);  // counter = cycles since POST
      end
      SF_WAIT: begin
        if (cnt_q != FEAT_MAX) cnt_d = cnt_q + 1'b1;
        if (cnt_q > RB_IGNORE && rb_ready) begin
          state_d = SF_DONE;
        end else if (cnt_q >= FEAT_LAST) begin
          timeout_d = 1'b1;
          state_d   = SF_DONE;
        end
      end
      SF_DONE: begin
        state_d = SF_IDLE;
        cnt_d   = '0;
      end
      default: state_d = SF_IDLE;
    endcase
  end

  // State and captured request registers.
  always_ff @(posedge onfi_clk or negedge onfi_rst_n) begin
    if (!onfi_rst_n) begin
      state_q   <= SF_IDLE;
      cnt_q     <= '0;
      beat_q    <= 2'd0;
      addr_q    <= 8'h00;
      param_q   <= 32'h0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      param_q   <= param_d;
      timeout_q <= timeout_d;
    end
  end

  // Pin decode from state; reset forces IDLE so the bus releases at once.
  always_comb begin
    bus.onfi_cen    = 1'b1;
    bus.onfi_cle    = 1'b0;
    bus.onfi_ale    = 1'b0;
    bus.onfi_wen    = 1'b1;
    bus.onfi_dq_en  = 1'b0;
    bus.onfi_dqs_o  = 1'b0;
    bus.onfi_dqs_en = 1'b0;
    bus.busy        = (state_q != SF_IDLE);
    bus.done        = 1'b0;
    bus.timeout     = timeout_q;
    dq_byte         = 8'h00;
    case (state_q)
      SF_CMD: begin
        bus.onfi_cen   = 1'b0;
        bus.onfi_cle   = 1'b1;
        bus.onfi_wen   = 1'b0;
        bus.onfi_dq_en = 1'b1;
        dq_byte        = CMD_SET_FEATURE;
      end
      SF_ADDR: begin
        bus.onfi_cen   = 1'b0;
        bus.onfi_ale   = 1'b1;
        bus.onfi_wen   = 1'b0;
        bus.onfi_dq_en = 1'b1;
        dq_byte        = addr_q;
      end
      SF_ADL, SF_WAIT: bus.onfi_cen = 1'b0;
      SF_PRE: begin
        bus.onfi_cen    = 1'b0;
        bus.onfi_dq_en  = 1'b1;
        bus.onfi_dqs_en = 1'b1;
        dq_byte         = param_q[7:0];
      end
      SF_DATA: begin
        // NV-DDR data cycle: CLE and ALE both high, DQS 1,0,1,0
        bus.onfi_cen    = 1'b0;
        bus.onfi_cle    = 1'b1;
        bus.onfi_ale    = 1'b1;
        bus.onfi_dq_en  = 1'b1;
        bus.onfi_dqs_en = 1'b1;
        bus.onfi_dqs_o  = ~beat_q[0];
        dq_byte         = param_q[{beat_q, 3'b000} +: 8];
      end
      SF_POST: begin
        // DQS postamble low; DQ holds P4 until the drivers release
        bus.onfi_cen    = 1'b0;
        bus.onfi_dq_en  = 1'b1;
        bus.onfi_dqs_en = 1'b1;
        dq_byte         = param_q[31:24];
      end
      SF_DONE: bus.done = 1'b1;
      default: ;
    endcase
    bus.onfi_dq_o = DQ_W'(dq_byte);
  end

endmodule

// File: tb/tb_set_feature.sv
// Directed bench for set_feature: reset, basic write, tADL gap, timeout,
// start gating, reset mid-transfer and back-to-back starts.
module tb_set_feature;
  localparam int unsigned T_ADL  = 14;
  localparam int unsigned T_FEAT = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  set_feature_if #(.DQ_W(8)) bus ();

  set_feature #(
    .ONFI_FRE      (200),
    .DQ_W          (8),
    .T_ADL_CYC     (T_ADL),
    .T_FEAT_TO_CYC (T_FEAT)
  ) dut (
    .onfi_clk   (clk),
    .onfi_rst_n (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got no summary by time %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [7:0] a, input logic [31:0] p);
    @(negedge clk);
    bus.addr  = a;
    bus.param = p;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Records one transfer starting at the current CMD cycle; returns at DONE.
  // rb_low_len > 0 pulls R/B# low at POST and releases it that many cycles later.
  task automatic watch_xfer(input int rb_low_len, input int max_wait,
                            output bit found, output logic [7:0] cmd_b,
                            output logic [7:0] addr_b, output int gap, output bit gap_ok,
                            output logic [31:0] data, output logic [3:0] dqs_pat,
                            output int post_to_done, output logic to_flag);
    int n;
    int a_n;
    int p_n;
    found = 0; cmd_b = 8'h00; addr_b = 8'h00; gap = -1; gap_ok = 1;
    data = 32'h0; dqs_pat = 4'h0; post_to_done = -1; to_flag = 1'b0;
    n = 0;
    while (n < 20 && !(bus.onfi_cle && !bus.onfi_ale && !bus.onfi_cen)) begin
      @(negedge clk); n++;
    end
    if (n >= 20) return;
    found = 1;
    cmd_b = bus.onfi_dq_o;
    @(negedge clk); n++;
    addr_b = bus.onfi_dq_o;
    a_n = n;
    @(negedge clk); n++;
    while (!(bus.onfi_dqs_en && bus.onfi_dqs_o) && n < a_n + 40) begin
      if (!bus.onfi_dqs_en && (bus.onfi_dq_en || !bus.onfi_wen)) gap_ok = 0;
      @(negedge clk); n++;
    end
    gap = n - a_n;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin @(negedge clk); n++; end
      data[8*b +: 8] = bus.onfi_dq_o;
      dqs_pat[3-b]   = bus.onfi_dqs_o;
    end
    @(negedge clk); n++;
    p_n = n;
    if (rb_low_len > 0) bus.onfi_rb_n = 1'b0;
    while (!bus.done && n < p_n + max_wait) begin
      @(negedge clk); n++;
      if (rb_low_len > 0 && n - p_n == rb_low_len) bus.onfi_rb_n = 1'b1;
    end
    if (bus.done) begin
      post_to_done = n - p_n;
      to_flag = bus.timeout;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.onfi_cen, bus.onfi_cle, bus.onfi_ale, bus.onfi_wen, bus.onfi_dq_en, bus.onfi_dqs_o,
         bus.onfi_dqs_en, bus.busy, bus.done, bus.timeout} !== 10'b1001000000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 1001000000",
               {bus.onfi_cen, bus.onfi_cle, bus.onfi_ale, bus.onfi_wen, bus.onfi_dq_en,
                bus.onfi_dqs_o, bus.onfi_dqs_en, bus.busy, bus.done, bus.timeout});
    end
    checks++;
    if (bus.onfi_dq_o !== 8'h00) begin
      failures++; $display("FAIL reset_dq: got %h required 00", bus.onfi_dq_o);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    bit found, gok; logic [7:0] c, a; int gap, ptd; logic [31:0] d; logic [3:0] q; logic to;
    pulse_start(8'h01, 32'h0000_0005);
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b required 1", bus.busy); end
    watch_xfer(20, 60, found, c, a, gap, gok, d, q, ptd, to);
    checks++;
    if ({found, c, a} !== {1'b1, 8'hEF, 8'h01}) begin
      failures++; $display("FAIL basic_cmd_addr: got %b/%h/%h required 1/ef/01", found, c, a);
    end
    checks++;
    if (d !== 32'h0000_0005) begin failures++; $display("FAIL basic_data: got %h required 00000005", d); end
    checks++;
    if (q !== 4'b1010) begin failures++; $display("FAIL basic_dqs: got %b required 1010", q); end
    checks++;
    if (ptd !== 23) begin failures++; $display("FAIL basic_rb_done: got %0d required 23", ptd); end
    checks++;
    if (to !== 1'b0) begin failures++; $display("FAIL basic_timeout: got %b required 0", to); end
    @(negedge clk);
    checks++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      failures++; $display("FAIL basic_done_pulse: got done,busy=%b required 00", {bus.done, bus.busy});
    end
  endtask

  task automatic test_tadl();
    bit found, gok; logic [7:0] c, a; int gap, ptd; logic [31:0] d; logic [3:0] q; logic to;
    pulse_start(8'h10, 32'hA5C3_5A3C);
    watch_xfer(0, 20, found, c, a, gap, gok, d, q, ptd, to);
    checks++;
    if (gap !== T_ADL + 2) begin failures++; $display("FAIL tadl_gap: got %0d required %0d", gap, T_ADL + 2); end
    checks++;
    if (gok !== 1'b1) begin failures++; $display("FAIL tadl_bus_idle: got %b required 1", gok); end
    checks++;
    if ({a, d} !== {8'h10, 32'hA5C3_5A3C}) begin
      failures++; $display("FAIL tadl_addr_data: got %h/%h required 10/a5c35a3c", a, d);
    end
    checks++;
    if (ptd !== 4) begin failures++; $display("FAIL tadl_min_wait: got %0d required 4", ptd); end
  endtask

  task automatic test_timeout();
    bit found, gok; logic [7:0] c, a; int gap, ptd; logic [31:0] d; logic [3:0] q; logic to;
    pulse_start(8'h01, 32'h0000_0003);
    watch_xfer(1000, 450, found, c, a, gap, gok, d, q, ptd, to);
    checks++;
    if (ptd !== T_FEAT) begin failures++; $display("FAIL to_cycle: got %0d required %0d", ptd, T_FEAT); end
    checks++;
    if (to !== 1'b1) begin failures++; $display("FAIL to_flag: got %b required 1", to); end
    bus.onfi_rb_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.timeout !== 1'b1) begin failures++; $display("FAIL to_sticky: got %b required 1", bus.timeout); end
    pulse_start(8'h01, 32'h0000_0005);
    checks++;
    if ({bus.onfi_cle, bus.timeout} !== 2'b10) begin
      failures++; $display("FAIL to_clear: got cle,timeout=%b required 10", {bus.onfi_cle, bus.timeout});
    end
    watch_xfer(0, 20, found, c, a, gap, gok, d, q, ptd, to);
    checks++;
    if ({ptd, to} !== {32'd4, 1'b0}) begin
      failures++; $display("FAIL to_recover: got %0d/%b required 4/0", ptd, to);
    end
  endtask

  task automatic test_start_gating();
    int cle_cnt;
    bit seen_done;
    bus.onfi_rb_n = 1'b0;
    repeat (4) @(negedge clk);
    pulse_start(8'h01, 32'h1);
    cle_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.onfi_cle) cle_cnt++;
      @(negedge clk);
    end
    checks++;
    if ({cle_cnt, bus.busy} !== {32'd0, 1'b0}) begin
      failures++; $display("FAIL gate_rb_low: got cle=%0d busy=%b required 0/0", cle_cnt, bus.busy);
    end
    bus.onfi_rb_n = 1'b1;
    repeat (3) @(negedge clk);
    pulse_start(8'h02, 32'h1122_3344);
    checks++;
    if (bus.onfi_cle !== 1'b1) begin failures++; $display("FAIL gate_first_cmd: got %b required 1", bus.onfi_cle); end
    repeat (5) @(negedge clk);
    pulse_start(8'hFF, 32'h0);
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL gate_busy_hold: got %b required 1", bus.busy); end
    cle_cnt = 0;
    seen_done = 0;
    for (int i = 0; i < 60 && !seen_done; i++) begin
      if (bus.onfi_cle && !bus.onfi_ale) cle_cnt++;
      if (bus.done) seen_done = 1;
      else @(negedge clk);
    end
    checks++;
    if ({cle_cnt, seen_done} !== {32'd0, 1'b1}) begin
      failures++; $display("FAIL gate_while_busy: got cmd=%0d done=%b required 0/1", cle_cnt, seen_done);
    end
    cle_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.onfi_cle) cle_cnt++;
    end
    checks++;
    if ({cle_cnt, bus.busy} !== {32'd0, 1'b0}) begin
      failures++; $display("FAIL gate_no_restart: got cle=%0d busy=%b required 0/0", cle_cnt, bus.busy);
    end
  endtask

  task automatic test_reset_mid_data();
    bit found, gok; logic [7:0] c, a; int gap, ptd; logic [31:0] d; logic [3:0] q; logic to;
    int n;
    int dones;
    pulse_start(8'h01, 32'hDEAD_BEEF);
    n = 0;
    while (!(bus.onfi_dqs_en && bus.onfi_dqs_o) && n < 30) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.onfi_dq_o !== 8'hAD) begin failures++; $display("FAIL rst_beat2: got %h required ad", bus.onfi_dq_o); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.onfi_cen, bus.onfi_dq_en, bus.onfi_dqs_en, bus.busy} !== 4'b1000) begin
      failures++;
      $display("FAIL rst_release: got cen,dq_en,dqs_en,busy=%b required 1000",
               {bus.onfi_cen, bus.onfi_dq_en, bus.onfi_dqs_en, bus.busy});
    end
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    checks++;
    if (dones !== 0) begin failures++; $display("FAIL rst_no_done: got %0d required 0", dones); end
    pulse_start(8'h01, 32'h0403_0201);
    watch_xfer(0, 20, found, c, a, gap, gok, d, q, ptd, to);
    checks++;
    if ({found, c, a, d, q, ptd} !== {1'b1, 8'hEF, 8'h01, 32'h0403_0201, 4'b1010, 32'd4}) begin
      failures++;
      $display("FAIL rst_clean_seq: got %b/%h/%h/%h/%b/%0d required 1/ef/01/04030201/1010/4",
               found, c, a, d, q, ptd);
    end
  endtask

  task automatic test_back_to_back();
    bit found, gok; logic [7:0] c, a; int gap, ptd; logic [31:0] d; logic [3:0] q; logic to;
    int extra;
    @(negedge clk);
    bus.addr  = 8'h01;
    bus.param = 32'h1111_2222;
    bus.start = 1'b1;
    @(negedge clk);
    bus.param = 32'h3333_4444;
    watch_xfer(0, 20, found, c, a, gap, gok, d, q, ptd, to);
    checks++;
    if ({found, d, ptd} !== {1'b1, 32'h1111_2222, 32'd4}) begin
      failures++; $display("FAIL b2b_first: got %b/%h/%0d required 1/11112222/4", found, d, ptd);
    end
    // DONE, then IDLE (start accepted), then the second CMD
    @(negedge clk);
    checks++;
    if ({bus.onfi_cle, bus.busy} !== 2'b00) begin
      failures++; $display("FAIL b2b_idle: got cle,busy=%b required 00", {bus.onfi_cle, bus.busy});
    end
    @(negedge clk);
    checks++;
    if ({bus.onfi_cle, bus.onfi_dq_o} !== {1'b1, 8'hEF}) begin
      failures++; $display("FAIL b2b_second_cmd: got %b/%h required 1/ef", bus.onfi_cle, bus.onfi_dq_o);
    end
    bus.start = 1'b0;
    bus.param = 32'h5555_6666;
    watch_xfer(0, 20, found, c, a, gap, gok, d, q, ptd, to);
    checks++;
    if ({found, d} !== {1'b1, 32'h3333_4444}) begin
      failures++; $display("FAIL b2b_second_param: got %b/%h required 1/33334444", found, d);
    end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.onfi_cle) extra++;
    end
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL b2b_stop: got %0d cle cycles required 0", extra); end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.addr      = 8'h00;
    bus.param     = 32'h0;
    bus.onfi_rb_n = 1'b1;
    test_reset();
    test_basic();
    test_tadl();
    test_timeout();
    test_start_gating();
    test_reset_mid_data();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
